servo_ramp: RTL and testbench
=============================

# servo_ramp

Command stage directly upstream of the servo PWM generator. Accepts a target angle (0–180°) over a valid/ready handshake, converts it to a 27 MHz duty count, and slews the `pwm_duty_value` word toward it by a bounded step once per 20 ms servo frame. The output connects straight to the PWM generator's duty input, so angle commands never cause full-range jumps on the servo.

## Interface
- `FRAME_CYCLES`, 540000: clock cycles per servo frame (27 MHz / 50 Hz).
- `DUTY_MIN`, 27000: duty count for 0° (1 ms).
- `DUTY_PER_DEG`, 150: duty counts per degree (180° → 54000, 2 ms).
- `DUTY_RESET`, 40500: duty count after reset (90°, 1.5 ms).
- `STEP_MAX`, 1500: largest duty change per frame (10°).
- `clk`  in  1  system clock. One clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  angle command valid.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_angle`  in  8  target angle in degrees. Values >180 clamp to 180.
- `pwm_duty_value`  out  32  duty count to the PWM generator. Registered.
- `busy`  out  1  high when state ≠ IDLE.
- `done`  out  1  one-cycle pulse when the output reaches the target.
- `frame_tick`  out  1  one-cycle pulse marking each frame boundary.

## Operation
- **Frame counter.**
  - `frame_cnt` counts 0..FRAME_CYCLES-1, then wraps to 0.
  - `frame_tick` = (frame_cnt == FRAME_CYCLES-1), combinational from the registered count.
  - The counter free-runs in all states.
- **States:** IDLE, CALC, RAMP.
- **Handshake.**
  - `cmd_ready` = (state ≠ CALC).
  - A command is accepted on any edge where `cmd_valid & cmd_ready`. The block then latches `min(cmd_angle,180)` and enters CALC.
  - Accepting a command in RAMP is a retarget. The in-progress ramp is abandoned and `pwm_duty_value` holds its current value.
- **CALC (exactly one cycle).**
  - Register `target = DUTY_MIN + angle*DUTY_PER_DEG`, computed unsigned at 32 bits.
  - If `target == pwm_duty_value`: go to IDLE and pulse `done`.
  - Otherwise go to RAMP.
- **RAMP.** On each edge with `frame_tick` high and no command accepted, let `diff = |target − pwm_duty_value|`:
  - If `diff ≤ STEP_MAX`: set `pwm_duty_value ← target`, pulse `done`, go to IDLE.
  - Otherwise move `pwm_duty_value` by ±STEP_MAX toward `target`.
  - Compute `diff` from an unsigned compare plus subtraction. No signed wrap is allowed.
- **Simultaneous events.**
  - Command accepted on a `frame_tick` edge in RAMP: the command wins and no step is taken on that edge.
  - `frame_tick` while in CALC or IDLE: ignored.
- **Stability.** `pwm_duty_value` changes only on RAMP `frame_tick` edges or on reset. It never changes in IDLE or CALC.
- **Reset.**
  - Reset dominates everything, including mid-ramp. It sets state IDLE, `frame_cnt` 0, `target` DUTY_RESET and `pwm_duty_value` DUTY_RESET.
  - Reset drives `done` 0, `busy` 0, `cmd_ready` 1 and `frame_tick` 0.

## Timing
- **Accept → CALC:** command accepted at edge N. `busy`=1 and `cmd_ready`=0 during cycle N+1.
- **Already at target:** edge N+1 returns to IDLE, and `done`=1 for the single cycle after N+1.
- **Ramp latency:** the output reaches the target after ceil(|Δ|/STEP_MAX) frame ticks following CALC. The first step happens on the first `frame_tick` edge after edge N+1.
- **Final step:** `done` is high for the cycle after the final step edge, and that is the same cycle `pwm_duty_value` shows the target.
- **Frame period:** `frame_tick` period is exactly FRAME_CYCLES. The first tick after reset release comes FRAME_CYCLES-1 edges after reset drops.
- **Outputs:** `pwm_duty_value`, `done` and state are registered. `cmd_ready` and `busy` decode from state only. `frame_tick` decodes combinationally from the registered `frame_cnt`.

## Test plan
Run the bench with `FRAME_CYCLES`=16 and all other parameters at default.
- **Reset values:** hold `reset` 3 cycles → `pwm_duty_value`=40500, `busy`=0, `done`=0, `cmd_ready`=1. The first `frame_tick` comes 15 edges after release.
- **Full ramp down:** send angle 0 from reset → 9 frame ticks with duty 39000, 37500, …, 28500, 27000. `done` pulses once with the final value. Then `busy`=0.
- **Clamp and ramp up:** send angle 200 → target 54000. There are 9 steps of +1500 from 40500, with the last step landing exactly on 54000. `cmd_ready`=0 only during CALC.
- **No-op command:** send angle 90 from reset → `done` 2 cycles after accept. No duty change, and no step on the next `frame_tick`.
- **Retarget on a tick edge:** send angle 0, wait 2 ticks (duty 37500), then present angle 180 on a `frame_tick` edge → duty stays 37500 on that edge. It then climbs +1500 per tick to 54000 with a single `done` at the end.
- **Reset mid-ramp:** assert `reset` during RAMP between ticks → the next cycle shows duty 40500 and IDLE. There is no `done` pulse, and `frame_cnt` restarts from 0.

Source files
------------

// File: rtl/servo_ramp.sv
// Servo command slew stage: accepts an angle, converts it to a PWM duty count and
// moves the duty output toward it by at most STEP_MAX once per servo frame.
module servo_ramp #(
   parameter int unsigned FRAME_CYCLES = 540000,
   parameter int unsigned DUTY_MIN     = 27000,
   parameter int unsigned DUTY_PER_DEG = 150,
   parameter int unsigned DUTY_RESET   = 40500,
   parameter int unsigned STEP_MAX     = 1500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_angle,
   output logic [31:0] pwm_duty_value,
   output logic        busy,
   output logic        done,
   output logic        frame_tick
);

   localparam int unsigned CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, CALC, RAMP} state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  frame_cnt_reg;
   logic [7:0]        angle_reg, angle_next;
   logic [31:0]       target_reg, target_next;
   logic [31:0]       duty_reg, duty_next;
   logic              done_reg, done_next;
   logic [31:0]       calc_target;
   logic [31:0]       diff;
   logic              duty_below;
   logic              accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_reg <= '0;
      end else if (frame_cnt_reg == CNT_LAST) begin
         frame_cnt_reg <= '0;
      end else begin
         frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end
   end

   assign frame_tick = (frame_cnt_reg == CNT_LAST);
   assign cmd_ready  = (state_reg != CALC);
   assign busy       = (state_reg != IDLE);
   assign accept     = cmd_valid & cmd_ready;

   assign calc_target = DUTY_MIN + (32'(angle_reg) * DUTY_PER_DEG);

   // Unsigned magnitude: pick the subtraction order that cannot wrap
   assign duty_below = (target_reg >= duty_reg);
   assign diff       = duty_below ? (target_reg - duty_reg) : (duty_reg - target_reg);

   always_comb begin
      state_next  = state_reg;
      angle_next  = angle_reg;
      target_next = target_reg;
      duty_next   = duty_reg;
      done_next   = 1'b0;
      if (accept) begin
         // A command always wins; an in-flight ramp simply stops where it is
         angle_next = (cmd_angle > 8'd180) ? 8'd180 : cmd_angle;
         state_next = CALC;
      end else begin
         case (state_reg)
            CALC: begin
               target_next = calc_target;
               if (calc_target == duty_reg) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  state_next = RAMP;
               end
            end
            RAMP: begin
               if (frame_tick) begin
                  if (diff <= STEP_MAX) begin
                     duty_next  = target_reg;
                     done_next  = 1'b1;
                     state_next = IDLE;
                  end else if (duty_below) begin
                     duty_next = duty_reg + STEP_MAX;
                  end else begin
                     duty_next = duty_reg - STEP_MAX;
                  end
               end
            end
            default: begin
               state_next = state_reg;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         angle_reg  <= '0;
         target_reg <= DUTY_RESET;
         duty_reg   <= DUTY_RESET;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         angle_reg  <= angle_next;
         target_reg <= target_next;
         duty_reg   <= duty_next;
         done_reg   <= done_next;
      end
   end

   assign pwm_duty_value = duty_reg;
   assign done           = done_reg;

endmodule

// File: tb/tb_servo_ramp.sv
// Directed bench for servo_ramp with a 16-cycle frame.
module tb_servo_ramp;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [7:0]  cmd_angle = 8'd0;
   logic        cmd_ready;
   logic [31:0] pwm_duty_value;
   logic        busy;
   logic        done;
   logic        frame_tick;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int d0 = 0;

   servo_ramp #(.FRAME_CYCLES(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_angle      (cmd_angle),
      .pwm_duty_value (pwm_duty_value),
      .busy           (busy),
      .done           (done),
      .frame_tick     (frame_tick)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reset held for 3 edges; ends at a negedge with reset released
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_duty", pwm_duty_value, 32'd40500);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_tick", 32'(frame_tick), 32'd0);
      reset = 1'b0;
   endtask

   task automatic first_tick(input string tag);
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (i == 14) check({tag, "_tick_early"}, 32'(frame_tick), 32'd0);
      end
      check({tag, "_tick_first"}, 32'(frame_tick), 32'd1);
   endtask

   task automatic send(input logic [7:0] angle);
      cmd_valid = 1'b1;
      cmd_angle = angle;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("calc_busy", 32'(busy), 32'd1);
      check("calc_ready", 32'(cmd_ready), 32'd0);
      check("calc_done", 32'(done), 32'd0);
   endtask

   // Leaves the bench at the negedge just before a frame_tick edge
   task automatic wait_tick();
      int n = 0;
      @(negedge clk);
      while (frame_tick !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("tick_timeout", 32'(frame_tick), 32'd1);
   endtask

   task automatic ramp(input int start, input int step, input int nsteps,
                       input logic [31:0] final_val, input bit last_done);
      logic [31:0] exp_v;
      logic [31:0] prev_v;
      prev_v = 32'(start);
      for (int k = 1; k <= nsteps; k++) begin
         wait_tick();
         check("hold_between_ticks", pwm_duty_value, prev_v);
         check("ramp_ready", 32'(cmd_ready), 32'd1);
         @(negedge clk);
         exp_v = (k == nsteps) ? final_val : 32'(start + k * step);
         check("ramp_duty", pwm_duty_value, exp_v);
         check("ramp_done", 32'(done), (k == nsteps && last_done) ? 32'd1 : 32'd0);
         check("ramp_busy", 32'(busy), (k == nsteps && last_done) ? 32'd0 : 32'd1);
         prev_v = exp_v;
      end
   endtask

   initial begin
      // Reset values and first tick timing
      do_reset();
      first_tick("rst");

      // Full ramp down to 0 degrees
      d0 = done_cnt;
      send(8'd0);
      @(negedge clk);
      check("down_ramp_state", 32'(cmd_ready), 32'd1);
      check("down_start_duty", pwm_duty_value, 32'd40500);
      ramp(40500, -1500, 9, 32'd27000, 1'b1);
      @(negedge clk);
      check("down_done_clear", 32'(done), 32'd0);
      check("down_idle", 32'(busy), 32'd0);
      check("down_done_count", 32'(done_cnt - d0), 32'd1);
      wait_tick();
      @(negedge clk);
      check("down_idle_stable", pwm_duty_value, 32'd27000);

      // Clamp 200 -> 180 and ramp up
      do_reset();
      d0 = done_cnt;
      send(8'd200);
      @(negedge clk);
      check("up_ramp_ready", 32'(cmd_ready), 32'd1);
      ramp(40500, 1500, 9, 32'd54000, 1'b1);
      @(negedge clk);
      check("up_idle", 32'(busy), 32'd0);
      check("up_done_count", 32'(done_cnt - d0), 32'd1);

      // No-op command at the current position
      do_reset();
      d0 = done_cnt;
      send(8'd90);
      @(negedge clk);
      check("noop_done", 32'(done), 32'd1);
      check("noop_busy", 32'(busy), 32'd0);
      check("noop_duty", pwm_duty_value, 32'd40500);
      @(negedge clk);
      check("noop_done_clear", 32'(done), 32'd0);
      wait_tick();
      @(negedge clk);
      check("noop_tick_duty", pwm_duty_value, 32'd40500);
      check("noop_tick_busy", 32'(busy), 32'd0);
      check("noop_done_count", 32'(done_cnt - d0), 32'd1);

      // Retarget presented on a frame_tick edge
      do_reset();
      d0 = done_cnt;
      send(8'd0);
      @(negedge clk);
      ramp(40500, -1500, 2, 32'd37500, 1'b0);
      wait_tick();
      check("rt_pre_duty", pwm_duty_value, 32'd37500);
      cmd_valid = 1'b1;
      cmd_angle = 8'd180;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("rt_no_step", pwm_duty_value, 32'd37500);
      check("rt_calc_ready", 32'(cmd_ready), 32'd0);
      check("rt_calc_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("rt_ramp_ready", 32'(cmd_ready), 32'd1);
      ramp(37500, 1500, 11, 32'd54000, 1'b1);
      @(negedge clk);
      check("rt_done_count", 32'(done_cnt - d0), 32'd1);

      // Reset in the middle of a ramp
      do_reset();
      send(8'd0);
      @(negedge clk);
      ramp(40500, -1500, 1, 32'd39000, 1'b0);
      repeat (3) @(negedge clk);
      check("mid_duty", pwm_duty_value, 32'd39000);
      check("mid_busy", 32'(busy), 32'd1);
      d0 = done_cnt;
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_duty", pwm_duty_value, 32'd40500);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ready", 32'(cmd_ready), 32'd1);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_tick", 32'(frame_tick), 32'd0);
      reset = 1'b0;
      first_tick("mid");
      @(negedge clk);
      check("mid_after_duty", pwm_duty_value, 32'd40500);
      check("mid_no_done", 32'(done_cnt - d0), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
